// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared RV32M multiply/divide constants and types
//
// Contents:
//   MULDIV_ITER    iterations per multi-cycle operation (XLEN)
//   FUNCT7_MULDIV  funct7 pattern that selects the M extension in decode
//   MulDivOp       funct3 encoding of the eight M operations
//   MulDivState    sequencer state encoding
//   neg_if         conditional two's complement helper
package muldiv_seq_pkg;

  localparam int unsigned MULDIV_ITER   = 32;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } MulDivOp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } MulDivState;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M multiply/divide sequencer for the EX stage
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   start         M-instruction present in EX (held while stalled)
//   flush         kill the in-flight operation
//   funct3        M operation select (MulDivOp)
//   opr1, opr2    forwarded rs1 / rs2 values
//   stall         combinational pipeline freeze
//   result_valid  one-cycle completion pulse (registered)
//   result        32-bit result, held between completions (registered)
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result
);
  import muldiv_seq_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [5:0] CNT_LAST = 6'(MULDIV_ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;

  // Operand decode for an incoming operation.
  logic        signed1, signed2, neg1, neg2;
  logic [31:0] mag1, mag2;
  logic        div_by_zero, div_overflow, fast;
  logic [31:0] fast_result;

  assign signed1 = (funct3 == MULH) || (funct3 == MULHSU) || (funct3 == DIV) || (funct3 == REM);
  assign signed2 = (funct3 == MULH) || (funct3 == DIV) || (funct3 == REM);
  assign neg1    = signed1 && opr1[31];
  assign neg2    = signed2 && opr2[31];
  assign mag1    = neg_if(opr1, neg1);
  assign mag2    = neg_if(opr2, neg2);

  assign div_by_zero  = funct3[2] && (opr2 == 32'd0);
  assign div_overflow = ((funct3 == DIV) || (funct3 == REM)) &&
                        (opr1 == 32'h8000_0000) && (opr2 == 32'hFFFF_FFFF);
  assign fast         = div_by_zero || div_overflow;
  // funct3[1] distinguishes REM/REMU from DIV/DIVU among the divide ops.
  assign fast_result  = div_by_zero ? (funct3[1] ? opr1 : 32'hFFFF_FFFF)
                                    : (funct3[1] ? 32'd0 : 32'h8000_0000);

  // One iteration of the shared shifter. Multiply keeps the multiplier in the
  // low half and shifts the running product in from the top; divide shifts the
  // dividend up into the partial remainder and drops quotient bits in at bit 0.
  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] acc_step;

  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};
  assign div_ge   = acc_q[63:31] >= {1'b0, b_q};
  // When div_ge holds the true difference is below the divisor, so 32 bits suffice.
  assign div_diff = acc_q[62:31] - b_q;
  assign acc_step = op_q[2] ? (div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0})
                            : {mul_sum, acc_q[31:1]};

  // Sign fix-up of the final iteration's value.
  logic [63:0] prod_fix;
  logic [31:0] fix_result;

  assign prod_fix = (sign1_q ^ sign2_q) ? (~acc_step + 64'd1) : acc_step;

  always_comb begin
    fix_result = 32'd0;
    if (!op_q[2]) begin
      fix_result = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end else if (!op_q[1]) begin
      fix_result = neg_if(acc_step[31:0], sign1_q ^ sign2_q);
    end else begin
      fix_result = neg_if(acc_step[63:32], sign1_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = funct3;
          sign1_d = neg1;
          sign2_d = neg2;
          cnt_d   = 6'd0;
          acc_d   = {32'd0, mag1};
          b_d     = mag2;
          if (fast) begin
            result_d = fast_result;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = fix_result;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      // The completing instruction is still in EX here, so start is ignored.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // flush wins over everything: no result and no result update.
    if (flush) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      op_q     <= 3'd0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign stall        = ((state_q == ST_IDLE) && start && !flush) || (state_q == ST_BUSY);
  assign result_valid = valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opr1 = 32'd0;
  logic [31:0] opr2 = 32'd0;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  muldiv_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .funct3       (funct3),
    .opr1         (opr1),
    .opr2         (opr2),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", result_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency_cycle", cyc, e.at);
      end
    end
  end

  // Caller has just passed a rising edge (+1); this cycle is cycle 0.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat);
    int c0;
    start  = 1'b1;
    funct3 = f3;
    opr1   = a;
    opr2   = b;
    c0     = cyc;
    sb.push_back('{e, c0 + lat});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("stall", stall, (k < lat));
      check("valid", result_valid, (k == lat));
      if (k < lat) @(posedge clk);
    end
    // start stays high through DONE; drop it in the following IDLE cycle.
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("stall_idle", stall, 1'b0);
    check("valid_idle", result_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;

    @(posedge clk); #1; run_op(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    @(posedge clk); #1; run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    @(posedge clk); #1; run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    @(posedge clk); #1; run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    @(posedge clk); #1; run_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    @(posedge clk); #1; run_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    @(posedge clk); #1; run_op(DIVU,   32'd100,       32'd7,         32'd14,        33);
    @(posedge clk); #1; run_op(REMU,   32'd100,       32'd7,         32'd2,         33);
    @(posedge clk); #1; run_op(REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    @(posedge clk); #1; run_op(DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    @(posedge clk); #1; run_op(DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    @(posedge clk); #1; run_op(REM,    32'd5,         32'd0,         32'd5,         1);
    @(posedge clk); #1; run_op(REMU,   32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1);
    @(posedge clk); #1; run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    @(posedge clk); #1; run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // flush in BUSY cycle 10, new operation started in cycle 11
    @(posedge clk); #1;
    start = 1'b1; funct3 = MUL; opr1 = 32'd123; opr2 = 32'd456;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("stall_flush_cycle", stall, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("stall_after_flush", stall, 1'b0);
    check("valid_after_flush", result_valid, 1'b0);
    #1;
    run_op(DIVU, 32'd9, 32'd3, 32'd3, 33);

    // reset in BUSY cycle 5
    @(posedge clk); #1;
    start = 1'b1; funct3 = MULHU; opr1 = 32'h1234_5678; opr2 = 32'h9ABC_DEF0;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_busy_stall", stall, 1'b0);
    check("rst_busy_valid", result_valid, 1'b0);
    check("rst_busy_result", result, 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("stall_quiet", stall, 1'b0);

    check("pending_results", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle RV32M multiply/divide sequencer beside the ALU in the execute stage. It accepts one M-extension operation at a time using the already-forwarded operands. It holds the pipeline with a stall while it iterates, then presents a 32-bit result for one cycle. A single shared 64-bit accumulator/shifter serves all eight M operations.

## Interface
- MULDIV_ITER, 32: iteration count. Fixed by XLEN and not intended to be overridden.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  valid M-instruction in EX (enable && M-op decode). Held high by the pipeline while stalled.
- flush  in  1  kill the in-flight operation (branch/exception). Synchronous.
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opr1  in  32  rs1 value after forwarding
- opr2  in  32  rs2 value after forwarding
- stall  out  1  combinational. Freezes IF/ID/EX.
- result_valid  out  1  registered. High exactly one cycle per completed operation.
- result  out  32  registered. Valid when result_valid is high. Otherwise holds the last value.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, start && !flush:
  - latch funct3, sign flags and |opr1|, |opr2|.
  - Signed only for MULH, DIV and REM (both operands), and for MULHSU (opr1 only).
  - Clear the 6-bit counter.
  - Go to BUSY, except for a fast case, which goes straight to DONE.
- Fast cases:
  - divisor == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return opr1.
  - DIV with opr1 = 0x80000000 and opr2 = 0xFFFFFFFF: returns 0x80000000. REM of the same operands returns 0.
- BUSY performs one iteration per cycle on the unsigned magnitudes; the counter increments each cycle. After iteration MULDIV_ITER-1, go to DONE.
  - Multiply: shift-add, 64-bit product.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
- Result fix-up, applied when entering DONE:
  - Multiply: negate the 64-bit product if sign1^sign2 (signed operands only). MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
  - DIV: negate the quotient if sign1^sign2.
  - REM: negate the remainder if sign1.
- DONE: result_valid = 1, stall = 0. Go to IDLE unconditionally. start is ignored here, because the same instruction is still in EX and leaves at the end of this cycle.
- stall = (state==IDLE && start && !flush) || state==BUSY.
- flush in any state: go to IDLE next cycle, no result_valid. flush has priority over start in the same cycle.
- rst: state IDLE, counter 0, stall 0, result_valid 0, result 0x00000000, accumulator 0.

## Timing
- Cycle 0: start is sampled in IDLE. stall is high in this same cycle.
- Normal operation:
  - BUSY occupies cycles 1..32 with stall high.
  - DONE is cycle 33, with result_valid high and stall low.
  - Total latency is 33 cycles; the pipeline is stalled for 33 cycles.
- Fast case: DONE in cycle 1. Latency 1, one stall cycle.
- Back-to-back M operations: the next start is accepted in the IDLE cycle immediately after DONE. Throughput is one operation per 34 cycles.
- flush or rst in cycle k of BUSY: stall is low in cycle k+1 and no result is produced. A start in cycle k+1 is accepted normally.
- result is updated only on entry to DONE. It holds its value through IDLE and BUSY.

## Structure
- The shared package (common) gets:
  - the funct3 enum MulDivOp (MUL..REMU),
  - the MULDIV_ITER constant,
  - the state enum MulDivState {IDLE, BUSY, DONE}.
- The RV32M funct7 = 0000001 decode constant also goes in the package; decode uses it to raise start.
- Single module. The FSM and iterative datapath share registers tightly, so no sub-module is warranted.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> result 0xFFFFFFEB. stall high cycles 0–32; result_valid only in cycle 33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD, REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14, REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with result_valid in cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- flush asserted in BUSY cycle 10 -> stall low in cycle 11, no result_valid. A new DIVU 9/3 started in cycle 11 -> 3 in cycle 44.
- rst asserted in BUSY cycle 5 -> all outputs 0 the next cycle. Separately: start held high through DONE -> exactly one result_valid pulse, and the FSM is in IDLE after DONE.
